// File: rtl/sample_pacer_pkg.sv
// rtl/sample_pacer_pkg.sv - shared defaults and handshake state type for sample_pacer
// Contents:
//   DEF_SAMPLE_WIDTH, DEF_DEPTH, DEF_UNDERRUN_WIDTH - default parameter values
//   hs_state_t - CPU write handshake states (IDLE, ACK)
package sample_pacer_pkg;

  localparam int DEF_SAMPLE_WIDTH   = 16;
  localparam int DEF_DEPTH          = 8;
  localparam int DEF_UNDERRUN_WIDTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } hs_state_t;

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - single-clock sample FIFO with registered occupancy
// Ports:
//   clock, reset_n   - rising-edge clock, asynchronous active-low reset
//   push, push_data  - write request and data (ignored when full)
//   pop              - read request (ignored when empty)
//   head             - entry at the read pointer, valid when not empty
//   full, empty      - occupancy flags derived from level
//   level            - registered occupancy after the last edge
module sample_fifo
  import sample_pacer_pkg::*;
#(
  parameter int WIDTH = DEF_SAMPLE_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LEVEL_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LEVEL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; only the pointers and level define validity.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers are log2(DEPTH) bits, so they wrap naturally at DEPTH.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LEVEL_W'(1);
        2'b01:   level <= level - LEVEL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sample_pacer.sv
// rtl/sample_pacer.sv - paces buffered CPU audio samples out on the 8.1 kHz tick
// Optional build macro: SAMPLE_PACER_MUTE_ON_UNDERRUN_EN (underrun loads silence)
// Ports:
//   clock, reset_n  - main clock, asynchronous active-low reset
//   tick_in         - asynchronous 8.1 kHz tick, synchronized internally
//   enable          - 1 paces samples out, 0 ignores ticks
//   command         - CPU four-phase write request, sample_in valid while high
//   sample_in       - write data
//   response        - handshake acknowledge
//   sample_out      - current sample to the speaker path
//   sample_strobe   - one-cycle pulse per accepted tick
//   fifo_level      - registered FIFO occupancy
//   underrun_count  - saturating count of ticks that found the FIFO empty
module sample_pacer
  import sample_pacer_pkg::*;
#(
  parameter int SAMPLE_WIDTH   = DEF_SAMPLE_WIDTH,
  parameter int DEPTH          = DEF_DEPTH,
  parameter int UNDERRUN_WIDTH = DEF_UNDERRUN_WIDTH
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        tick_in,
  input  logic                        enable,
  input  logic                        command,
  input  logic [SAMPLE_WIDTH-1:0]     sample_in,
  output logic                        response,
  output logic [SAMPLE_WIDTH-1:0]     sample_out,
  output logic                        sample_strobe,
  output logic [$clog2(DEPTH+1)-1:0]  fifo_level,
  output logic [UNDERRUN_WIDTH-1:0]   underrun_count
);

  logic s1, s2, s3;
  logic tick;
  logic pop;
  logic underrun;
  logic push;
  logic full;
  logic empty;
  logic [SAMPLE_WIDTH-1:0]   head;
  logic [SAMPLE_WIDTH-1:0]   underrun_fill;
  logic [UNDERRUN_WIDTH-1:0] underrun_next;
  hs_state_t                 state;
  hs_state_t                 state_next;

  // Synchronizer resets to all ones so a tick_in already high at reset
  // release never looks like a rising edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= tick_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // enable gates only the detect cycle; the synchronizer runs regardless.
  assign tick     = s2 & ~s3 & enable;
  assign pop      = tick & ~empty;
  assign underrun = tick & empty;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // One FIFO write per handshake: the push happens only on the IDLE->ACK
  // transition, and a full FIFO keeps the request waiting in IDLE.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    case (state)
      IDLE: begin
        if (command && !full) begin
          push       = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        if (!command) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign response = (state == ACK);

`ifdef SAMPLE_PACER_MUTE_ON_UNDERRUN_EN
  assign underrun_fill = '0;
`else
  assign underrun_fill = sample_out;
`endif

  always_comb begin
    underrun_next = underrun_count;
    if (underrun && (underrun_count != '1)) begin
      underrun_next = underrun_count + UNDERRUN_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sample_out     <= '0;
      sample_strobe  <= 1'b0;
      underrun_count <= '0;
    end else begin
      sample_strobe  <= tick;
      underrun_count <= underrun_next;
      if (pop) begin
        sample_out <= head;
      end else if (underrun) begin
        sample_out <= underrun_fill;
      end
    end
  end

  // No bypass: a push in the same cycle as an underrun tick lands in the FIFO.
  sample_fifo #(
    .WIDTH (SAMPLE_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (sample_in),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

endmodule

// File: doc/sample_pacer.md
Name: sample_pacer

Overview:
- Sits directly downstream of the clock generator, in the main E100 `clock` domain.
- Consumes the asynchronous 8.1 kHz audio tick (`clock_8_1k`) and emits one buffered audio sample per tick to the speaker/codec path.
- The CPU loads samples through a four-phase command/response handshake into a small FIFO.
- Decouples CPU write bursts from the fixed audio sample rate and counts underruns.

Parameters:
- SAMPLE_WIDTH, 16, bits per audio sample.
- DEPTH, 8, FIFO entries; must be a power of two, ≥2.
- UNDERRUN_WIDTH, 16, width of the saturating underrun counter.

Ports:
- clock  input  1  main E100 clock; all logic is on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- tick_in  input  1  8.1 kHz clock from the clock generator; asynchronous to `clock`.
- enable  input  1  1 = pace samples out; 0 = ticks ignored.
- command  input  1  CPU write request (four-phase handshake).
- sample_in  input  SAMPLE_WIDTH  write data; valid while `command`=1.
- response  output  1  handshake acknowledge.
- sample_out  output  SAMPLE_WIDTH  current sample to the speaker path.
- sample_strobe  output  1  one-cycle pulse when `sample_out` updates.
- fifo_level  output  $clog2(DEPTH+1)  current FIFO occupancy.
- underrun_count  output  UNDERRUN_WIDTH  saturating count of ticks that found the FIFO empty.

Behaviour:
- Clocking and reset: one clock (`clock`); reset is asynchronous and active-low (`reset_n`).
- Reset values:
  - `response`, `sample_out`, `sample_strobe`, `fifo_level`, `underrun_count` = 0.
  - FIFO empty.
  - Synchronizer flops s1/s2/s3 = 1, so no spurious tick at reset release even if `tick_in` is high.
- Tick detection:
  - s1<=tick_in, s2<=s1, s3<=s2.
  - tick = s2 & ~s3 & enable.
  - A `tick_in` rise first captured by s1 at edge N makes `sample_strobe` high for the cycle after edge N+2.
- On tick:
  - FIFO non-empty: pop the head into `sample_out`; `sample_strobe`=1 for one cycle.
  - FIFO empty: underrun. `sample_out` holds its last value (see the optional feature); `sample_strobe`=1; `underrun_count` increments and saturates at all-ones.
- enable=0: no pops, no strobes, no underrun counting. The synchronizer keeps running, so a tick edge already in flight when enable rises is honoured only if enable=1 in the detect cycle.
- Handshake FSM, states IDLE and ACK:
  - IDLE: if command=1 and FIFO not full → write `sample_in`, response<=1, go to ACK.
  - IDLE with command=1 and FIFO full: stall in IDLE with response=0 until space frees.
  - ACK: when command=0 → response<=0, go to IDLE. While command stays 1, no further writes occur (exactly one write per handshake).
- Same-cycle push and pop: both take effect and the level is unchanged. Pop on empty with a same-cycle push is an underrun; there is no bypass, and the pushed sample enters the FIFO.
- `fifo_level` is registered and reflects the post-edge occupancy. Read and write pointers are log2(DEPTH) bits and wrap naturally.
- Reset mid-handshake: FSM returns to IDLE and `response`=0. The CPU must drop `command` and retry.

Optional Feature:
- Macro: SAMPLE_PACER_MUTE_ON_UNDERRUN_EN.
- Defined: an underrun tick loads `sample_out` with 0 (silence) and still strobes.
- Undefined: an underrun tick re-strobes the previous `sample_out` unchanged.
- Underrun counting is identical in both builds.

Decomposition:
- Package `sample_pacer_pkg` holds:
  - default SAMPLE_WIDTH, DEPTH, UNDERRUN_WIDTH constants;
  - the handshake state typedef (IDLE, ACK).
- One sub-module, `sample_fifo`: synchronous single-clock FIFO with push/pop/full/empty/level, same asynchronous active-low reset.
- Synchronizer, tick detect, FSM and output register live in `sample_pacer`.

Test Plan (all with DEPTH=4):
- Reset release with tick_in held high → no strobe for 20 cycles; all outputs 0.
- Write 0x1111, 0x2222, 0x3333 via handshakes, then 3 ticks → strobes carry 0x1111, 0x2222, 0x3333 in order; level steps 3→0. Strobe appears in the cycle after edge N+2 of each captured tick_in rise.
- Write 5 samples with no ticks → 4 complete handshakes; the 5th `command` stalls with response=0 and level=4. One tick → response rises on the next cycle and level returns to 4.
- Empty FIFO, 3 ticks → underrun_count=3 and strobes fire. `sample_out` holds 0x3333 without the macro, or reads 0 with it. Force the count to 0xFFFE, then 3 more ticks → saturates at 0xFFFF.
- Level=1 with push and tick in the same cycle → level stays 1 and the popped value is the old head. Level=0 with push and tick in the same cycle → underrun +1 and level becomes 1.
- enable=0 with 2 ticks → no strobes, level unchanged. Assert reset_n low while response=1 → response drops immediately (asynchronous) and the FSM is in IDLE.
